// File: rtl/packetizer_4.sv
// rtl/packetizer_4.sv - 4-flit packetizer with a 2-entry elastic output buffer
module packetizer_4 #(
  parameter int WIDTH_PKT        = 36,
  parameter int WIDTH_DATA       = 12,
  parameter int VC_ADDRESS_WIDTH = 1,
  parameter int ADDRESS_WIDTH    = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WIDTH_DATA-1:0]       data_in,
  input  logic [ADDRESS_WIDTH-1:0]    dst_in,
  input  logic [VC_ADDRESS_WIDTH-1:0] vc_in,
  input  logic                        valid_in,
  output logic                        ready_out,
  output logic [WIDTH_PKT-1:0]        data_out,
  output logic                        valid_out,
  input  logic                        ready_in,
  output logic [15:0]                 pkt_count
);

  localparam int WIDTH_FLIT     = WIDTH_PKT / 4;
  localparam int WIDTH_DATA_IDL = WIDTH_PKT - 12 - 4*VC_ADDRESS_WIDTH - ADDRESS_WIDTH;
  localparam int HEAD_DW        = WIDTH_FLIT - 3 - VC_ADDRESS_WIDTH - ADDRESS_WIDTH;
  localparam int BODY_DW        = WIDTH_FLIT - 3 - VC_ADDRESS_WIDTH;

  localparam logic [2:0] CTRL_HEAD = 3'b110;
  localparam logic [2:0] CTRL_BODY = 3'b100;
  localparam logic [2:0] CTRL_TAIL = 3'b101;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t                    state;
  state_t                    state_n;
  logic                      head_ptr;
  logic                      wr_ptr;
  logic                      push;
  logic                      pop;
  logic [WIDTH_DATA_IDL-1:0] full_data;
  logic [WIDTH_PKT-1:0]      packed_word;
  logic [WIDTH_PKT-1:0]      mem [2];

  // Data is left-justified; the zero padding lands in the tail flit's LSBs.
  always_comb begin
    full_data = '0;
    full_data[WIDTH_DATA_IDL-1 -: WIDTH_DATA] = data_in;
  end

  assign packed_word = {
    CTRL_HEAD, vc_in, dst_in, full_data[WIDTH_DATA_IDL-1 -: HEAD_DW],
    CTRL_BODY, vc_in, full_data[WIDTH_DATA_IDL-1-HEAD_DW -: BODY_DW],
    CTRL_BODY, vc_in, full_data[WIDTH_DATA_IDL-1-HEAD_DW-BODY_DW -: BODY_DW],
    CTRL_TAIL, vc_in, full_data[BODY_DW-1:0]
  };

  assign push = valid_in & ready_out;
  assign pop  = valid_out & ready_in;

  // Second slot is only written while one entry is already held.
  assign wr_ptr = head_ptr ^ (state == ONE);

  always_comb begin
    state_n   = state;
    ready_out = 1'b1;
    valid_out = 1'b0;
    case (state)
      EMPTY: begin
        if (push) state_n = ONE;
      end
      ONE: begin
        valid_out = 1'b1;
        if (push && !pop)      state_n = TWO;
        else if (!push && pop) state_n = EMPTY;
      end
      TWO: begin
        valid_out = 1'b1;
        ready_out = 1'b0;
        if (pop) state_n = ONE;
      end
      default: begin
        state_n   = EMPTY;
        ready_out = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      head_ptr  <= 1'b0;
      mem[0]    <= '0;
      mem[1]    <= '0;
      pkt_count <= 16'd0;
    end else begin
      state <= state_n;
      if (push) mem[wr_ptr] <= packed_word;
      if (pop) begin
        head_ptr  <= ~head_ptr;
        pkt_count <= pkt_count + 16'd1;
      end
    end
  end

  assign data_out = mem[head_ptr];

endmodule

// File: tb/tb_packetizer_4.sv
// tb/tb_packetizer_4.sv - directed and scoreboarded bench for packetizer_4
module tb_packetizer_4;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] data_in;
  logic [3:0]  dst_in;
  logic [0:0]  vc_in;
  logic        valid_in;
  logic        ready_out;
  logic [35:0] data_out;
  logic        valid_out;
  logic        ready_in;
  logic [15:0] pkt_count;

  int total = 0;
  int bad   = 0;

  packetizer_4 dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .dst_in    (dst_in),
    .vc_in     (vc_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .data_out  (data_out),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .pkt_count (pkt_count)
  );

  always #5 clk = ~clk;

  // Packet layout written out bit by bit for the default parameters.
  function automatic logic [35:0] pack(input logic [11:0] d, input logic [3:0] dst, input logic v);
    return {3'b110, v, dst, d[11],
            3'b100, v, d[10:6],
            3'b100, v, d[5:1],
            3'b101, v, d[0], 4'b0000};
  endfunction

  // Inverse of the packet format, as the downstream depacketizer sees it.
  function automatic logic [11:0] depack(input logic [35:0] p);
    logic [15:0] full;
    full = {p[27], p[22:18], p[13:9], p[4:0]};
    return full[15:4];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; valid_in = 1'b0; ready_in = 1'b0;
    data_in = '0; dst_in = '0; vc_in = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid_out got=%b want=0", valid_out); end
    total++; if (ready_out !== 1'b1) begin bad++; $display("FAIL reset_ready_out got=%b want=1", ready_out); end
    total++; if (data_out !== 36'h0) begin bad++; $display("FAIL reset_data_out got=%h want=0", data_out); end
    total++; if (pkt_count !== 16'h0) begin bad++; $display("FAIL reset_pkt_count got=%0d want=0", pkt_count); end
  endtask

  task automatic test_format();
    do_reset();
    data_in = 12'hABC; dst_in = 4'h5; vc_in = 1'b1; ready_in = 1'b1; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    total++; if (data_out !== 36'hD5CAA7D60) begin bad++; $display("FAIL format_data got=%h want=d5caa7d60", data_out); end
    total++; if (valid_out !== 1'b1) begin bad++; $display("FAIL format_valid got=%b want=1", valid_out); end
    tick();
    total++; if (pkt_count !== 16'd1) begin bad++; $display("FAIL format_count got=%0d want=1", pkt_count); end
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL format_drain got=%b want=0", valid_out); end
  endtask

  task automatic test_round_trip();
    logic [11:0] d;
    logic [3:0]  a;
    logic        v;
    do_reset();
    ready_in = 1'b1;
    for (int i = 0; i < 24; i++) begin
      d = 12'($urandom); a = 4'($urandom); v = 1'($urandom);
      data_in = d; dst_in = a; vc_in = v; valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      total++;
      if (valid_out !== 1'b1 || depack(data_out) !== d || data_out[31:28] !== a || data_out[32] !== v)
        begin bad++; $display("FAIL round_trip got=%h want_data=%h dst=%h vc=%b", data_out, d, a, v); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    ready_in = 1'b0; dst_in = 4'h3; vc_in = 1'b0;
    valid_in = 1'b1; data_in = 12'h111;
    tick();
    total++; if (ready_out !== 1'b1) begin bad++; $display("FAIL bp_ready_one got=%b want=1", ready_out); end
    data_in = 12'h222;
    tick();
    valid_in = 1'b0;
    total++; if (ready_out !== 1'b0) begin bad++; $display("FAIL bp_ready_two got=%b want=0", ready_out); end
    total++; if (data_out !== pack(12'h111, 4'h3, 1'b0)) begin bad++; $display("FAIL bp_hold_a got=%h want=%h", data_out, pack(12'h111, 4'h3, 1'b0)); end
    tick();
    total++; if (data_out !== pack(12'h111, 4'h3, 1'b0) || valid_out !== 1'b1) begin bad++; $display("FAIL bp_stable got=%h", data_out); end
    ready_in = 1'b1;
    tick();
    total++; if (data_out !== pack(12'h222, 4'h3, 1'b0) || valid_out !== 1'b1) begin bad++; $display("FAIL bp_b_next got=%h want=%h", data_out, pack(12'h222, 4'h3, 1'b0)); end
    total++; if (ready_out !== 1'b1) begin bad++; $display("FAIL bp_ready_rise got=%b want=1", ready_out); end
    tick();
    total++; if (valid_out !== 1'b0 || pkt_count !== 16'd2) begin bad++; $display("FAIL bp_drain valid=%b count=%0d want 0/2", valid_out, pkt_count); end
  endtask

  task automatic test_streaming();
    int errs = 0;
    do_reset();
    ready_in = 1'b1; dst_in = 4'hA; vc_in = 1'b1;
    valid_in = 1'b1; data_in = 12'd0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (valid_out !== 1'b1 || ready_out !== 1'b1 || data_out !== pack(12'(i), 4'hA, 1'b1)) errs++;
      data_in = 12'(i + 1);
      if (i == 99) valid_in = 1'b0;
    end
    total++; if (errs != 0) begin bad++; $display("FAIL stream_order got_errs=%0d want=0", errs); end
    tick();
    total++; if (pkt_count !== 16'd100) begin bad++; $display("FAIL stream_count got=%0d want=100", pkt_count); end
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL stream_empty got=%b want=0", valid_out); end
  endtask

  task automatic test_random();
    logic [35:0] q[$];
    logic [35:0] exp_w;
    int sent = 0;
    int errs = 0;
    int budget;
    do_reset();
    while (sent < 1500) begin
      valid_in = ($urandom_range(0, 3) != 0);
      ready_in = ($urandom_range(0, 3) != 0);
      data_in = 12'($urandom); dst_in = 4'($urandom); vc_in = 1'($urandom);
      if (valid_in && ready_out) begin q.push_back(pack(data_in, dst_in, vc_in)); sent++; end
      if (valid_out && ready_in) begin
        if (q.size() == 0) errs++;
        else begin exp_w = q.pop_front(); if (data_out !== exp_w) errs++; end
      end
      tick();
    end
    valid_in = 1'b0; ready_in = 1'b1;
    budget = 10;
    while (valid_out && budget > 0) begin
      if (q.size() == 0) errs++;
      else begin exp_w = q.pop_front(); if (data_out !== exp_w) errs++; end
      tick();
      budget--;
    end
    total++; if (errs != 0) begin bad++; $display("FAIL random_scoreboard got_errs=%0d want=0", errs); end
    total++; if (q.size() != 0 || valid_out !== 1'b0) begin bad++; $display("FAIL random_drain left=%0d valid=%b want 0/0", q.size(), valid_out); end
  endtask

  task automatic test_reset_in_two();
    do_reset();
    ready_in = 1'b0; valid_in = 1'b1; data_in = 12'h5A5;
    tick();
    tick();
    total++; if (ready_out !== 1'b0) begin bad++; $display("FAIL rst2_setup got=%b want=0", ready_out); end
    rst = 1'b1; ready_in = 1'b1;
    tick();
    total++; if (valid_out !== 1'b0 || ready_out !== 1'b1 || data_out !== 36'h0 || pkt_count !== 16'h0)
      begin bad++; $display("FAIL rst2_outputs valid=%b ready=%b data=%h count=%0d", valid_out, ready_out, data_out, pkt_count); end
    rst = 1'b0; valid_in = 1'b0;
    tick();
    tick();
    total++; if (valid_out !== 1'b0 || pkt_count !== 16'h0) begin bad++; $display("FAIL rst2_stale valid=%b count=%0d want 0/0", valid_out, pkt_count); end
  endtask

  task automatic test_wrap();
    do_reset();
    ready_in = 1'b1; valid_in = 1'b1; data_in = 12'h001;
    repeat (65536) tick();
    total++; if (pkt_count !== 16'hFFFF) begin bad++; $display("FAIL wrap_max got=%h want=ffff", pkt_count); end
    tick();
    valid_in = 1'b0;
    total++; if (pkt_count !== 16'h0000) begin bad++; $display("FAIL wrap_zero got=%h want=0000", pkt_count); end
  endtask

  initial begin
    test_reset();
    test_format();
    test_round_trip();
    test_backpressure();
    test_streaming();
    test_random();
    test_reset_in_two();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
